// File: rtl/riscv_enc_pkg.sv
// Shared definitions for the RV64 instruction encoder.
//   - Opcodes of the supported formats (R, I-load, I-ALU, S, B).
//   - FSM state encoding of the encoder's control path.
//   - Bit positions of the fixed instruction fields. The immediate extractor
//     uses the same positions.
//   - imm12_fits(): true when a 64-bit sign-extended immediate fits in 12 bits.
package riscv_enc_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } enc_state_e;

  localparam int OPC_LSB = 0;
  localparam int RD_LSB  = 7;
  localparam int F3_LSB  = 12;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int F7_LSB  = 25;

  // Bits 63:11 must all be copies of bit 11 for a 12-bit signed immediate.
  function automatic logic imm12_fits(input logic [63:0] imm);
    return imm[63:11] == {53{imm[11]}};
  endfunction

endpackage

// File: rtl/instr_field_pack.sv
// instr_field_pack: purely combinational packing of decoded fields into a
// 32-bit RV64 instruction word.
// Configuration macro: IMM_RANGE_CHECK_EN. When it is defined, I/S/B
// immediates that do not fit in 12 signed bits are flagged illegal. When it is
// not defined, the immediate is truncated to 12 bits.
// Ports:
//   opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i   decoded fields
//   word_o    packed instruction (opcode bits always present)
//   legal_o   1 when opcode is supported (and immediate in range if checked)
module instr_field_pack
  import riscv_enc_pkg::*;
(
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [63:0] imm_i,
  output logic [31:0] word_o,
  output logic        legal_o
);

  logic imm_ok;

`ifdef IMM_RANGE_CHECK_EN
  assign imm_ok = imm12_fits(imm_i);
`else
  logic imm_hi_unused;
  assign imm_ok        = 1'b1;
  assign imm_hi_unused = ^imm_i[63:12];
`endif

  always_comb begin
    word_o  = '0;
    legal_o = 1'b0;
    word_o[OPC_LSB +: 7] = opcode_i;
    case (opcode_i)
      OP_R: begin
        word_o[RD_LSB  +: 5] = rd_i;
        word_o[F3_LSB  +: 3] = funct3_i;
        word_o[RS1_LSB +: 5] = rs1_i;
        word_o[RS2_LSB +: 5] = rs2_i;
        word_o[F7_LSB  +: 7] = funct7_i;
        legal_o = 1'b1;
      end
      OP_LOAD, OP_IALU: begin
        word_o[RD_LSB  +: 5] = rd_i;
        word_o[F3_LSB  +: 3] = funct3_i;
        word_o[RS1_LSB +: 5] = rs1_i;
        word_o[31:20]        = imm_i[11:0];
        legal_o = imm_ok;
      end
      OP_STORE: begin
        word_o[11:7]         = imm_i[4:0];
        word_o[F3_LSB  +: 3] = funct3_i;
        word_o[RS1_LSB +: 5] = rs1_i;
        word_o[RS2_LSB +: 5] = rs2_i;
        word_o[31:25]        = imm_i[11:5];
        legal_o = imm_ok;
      end
      OP_BRANCH: begin
        // imm is the branch offset in halfwords. Its bit k is offset bit k+1.
        word_o[7]            = imm_i[10];
        word_o[11:8]         = imm_i[3:0];
        word_o[F3_LSB  +: 3] = funct3_i;
        word_o[RS1_LSB +: 5] = rs1_i;
        word_o[RS2_LSB +: 5] = rs2_i;
        word_o[30:25]        = imm_i[9:4];
        word_o[31]           = imm_i[11];
        legal_o = imm_ok;
      end
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts decoded field bundles, packs them into RV64
// instruction words and streams them, with byte addresses, to the IMEM loader.
// Configuration macro: IMM_RANGE_CHECK_EN (see instr_field_pack).
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   start                          pulse: restart a program at BASE_ADDR
//   in_valid / in_ready            field bundle handshake
//   opcode, rd, rs1, rs2, funct3, funct7, imm_data   decoded fields
//   out_valid / out_ready          instruction word handshake
//   instruction, instr_addr        encoded word and its byte address
//   done                           DEPTH words emitted; held until start/reset
//   err                            pulse: bundle accepted but dropped
module instr_encoder
  import riscv_enc_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter int                DEPTH     = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [63:0]       imm_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       instruction,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              done,
  output logic              err
);

  localparam int             CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  enc_state_e        state_q;
  logic              out_valid_q;
  logic [31:0]       instr_q;
  logic [ADDR_W-1:0] addr_q;
  logic              done_q;
  logic              err_q;
  logic [CNT_W-1:0]  acc_q;
  logic [CNT_W-1:0]  emit_q;

  logic [31:0] packed_word;
  logic        packed_legal;
  logic        out_hs;
  logic        xfer;

  instr_field_pack u_pack (
    .opcode_i (opcode),
    .rd_i     (rd),
    .rs1_i    (rs1),
    .rs2_i    (rs2),
    .funct3_i (funct3),
    .funct7_i (funct7),
    .imm_i    (imm_data),
    .word_o   (packed_word),
    .legal_o  (packed_legal)
  );

  assign out_hs = out_valid_q && out_ready;
  // A bundle offered while start is high would be wiped by the restart,
  // so it is not acknowledged.
  assign in_ready = (state_q == RUN) && !start && (acc_q < DEPTH_C) &&
                    (!out_valid_q || out_ready);
  assign xfer = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      instr_q     <= '0;
      addr_q      <= BASE_ADDR;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      acc_q       <= '0;
      emit_q      <= '0;
    end else if (start) begin
      // Restart from any state. A word still waiting for out_ready is discarded.
      state_q     <= RUN;
      out_valid_q <= 1'b0;
      addr_q      <= BASE_ADDR;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      acc_q       <= '0;
      emit_q      <= '0;
    end else begin
      err_q <= xfer && !packed_legal;
      if (out_hs) begin
        addr_q <= addr_q + ADDR_W'(4);
        emit_q <= emit_q + CNT_W'(1);
      end
      // A new word may be loaded in the same cycle the old one leaves, so the
      // encoder sustains one word per cycle.
      if (xfer && packed_legal) begin
        out_valid_q <= 1'b1;
        instr_q     <= packed_word;
        acc_q       <= acc_q + CNT_W'(1);
      end else if (out_hs) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        RUN: begin
          if (emit_q == DEPTH_C && !out_valid_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid   = out_valid_q;
  assign instruction = instr_q;
  assign instr_addr  = addr_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  localparam int         DEPTH = 8;
  localparam logic [7:0] BASE  = 8'h20;

  typedef struct packed {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm;
  } bnd_t;

  typedef struct packed {
    logic [31:0] w;
    logic [7:0]  a;
    logic        is_b;
    logic [11:0] imm12;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  opcode = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [63:0] imm_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] instruction;
  logic [7:0]  instr_addr;
  logic        done;
  logic        err;

  int   checks = 0;
  int   errors = 0;
  int   words = 0;
  int   errs_issued = 0;
  int   err_seen = 0;
  int   cyc = 0;
  int   last_acc = 0;
  bit   rand_rdy = 0;
  bit   man_rdy = 0;
  bit   mon_en = 0;
  exp_t sb[$];

  instr_encoder #(.ADDR_W(8), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .imm_data(imm_data), .out_valid(out_valid), .out_ready(out_ready),
    .instruction(instruction), .instr_addr(instr_addr), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    else          out_ready = man_rdy;
  end

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  // Reference encoder, built from the standard RISC-V field layout with plain
  // arithmetic. For branches, the offset is twice the halfword immediate.
  function automatic void ref_encode(input bnd_t b, output logic [31:0] w, output bit ok);
    longint      si;
    int unsigned imm12, off, base;
    si    = $signed(b.imm);
    imm12 = {20'd0, b.imm[11:0]};
    ok    = 1;
    base  = (32'(b.rs1) << 15) + (32'(b.f3) << 12) + 32'(b.op);
`ifdef IMM_RANGE_CHECK_EN
    if (b.op != 7'h33 && (si < -2048 || si > 2047)) ok = 0;
`else
    if (si == 0) ok = 1;
`endif
    case (b.op)
      7'h33: w = (32'(b.f7) << 25) + (32'(b.rs2) << 20) + (32'(b.rd) << 7) + base;
      7'h03, 7'h13: w = (imm12 << 20) + (32'(b.rd) << 7) + base;
      7'h23: w = ((imm12 / 32) << 25) + (32'(b.rs2) << 20) + ((imm12 % 32) << 7) + base;
      7'h63: begin
        off = imm12 * 2;
        w = (((off >> 12) & 1) << 31) + (((off >> 5) & 63) << 25) + (32'(b.rs2) << 20)
          + (((off >> 1) & 15) << 8) + (((off >> 11) & 1) << 7) + base;
      end
      default: begin w = '0; ok = 0; end
    endcase
  endfunction

  function automatic bnd_t mk(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                              input logic [4:0] s2, input logic [2:0] f3, input logic [63:0] imm);
    bnd_t b;
    b.op = op; b.rd = d; b.rs1 = s1; b.rs2 = s2; b.f3 = f3; b.f7 = 7'h20; b.imm = imm;
    return b;
  endfunction

  // Called at posedge+1. If use_x is set, xw is the required word; otherwise
  // the reference model supplies it.
  task automatic send(input bnd_t b, input bit hold, input bit use_x, input logic [31:0] xw);
    logic [31:0] w;
    bit          ok;
    int          n;
    exp_t        e;
    opcode = b.op; rd = b.rd; rs1 = b.rs1; rs2 = b.rs2;
    funct3 = b.f3; funct7 = b.f7; imm_data = b.imm; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin n++; @(negedge clk); end
    if (!in_ready) begin
      check("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      @(posedge clk); #1;
      return;
    end
    last_acc = cyc;
    ref_encode(b, w, ok);
    if (use_x) w = xw;
    if (ok) begin
      e.w = w; e.a = BASE + 8'(4 * words); e.is_b = (b.op == 7'h63); e.imm12 = b.imm[11:0];
      sb.push_back(e);
      words++;
    end else begin
      errs_issued++;
    end
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic do_start();
    in_valid = 1'b0;
    start = 1'b1;
    sb.delete();
    words = 0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || out_valid) && n < 300) begin n++; @(negedge clk); end
    check(nm, 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 20) begin n++; @(negedge clk); end
    check(nm, 64'(done), 64'd1);
    check({nm, "_in_ready"}, 64'(in_ready), 64'd0);
  endtask

  // Scoreboard monitor.
  logic        stall_prev = 1'b0;
  logic [31:0] prev_i;
  logic [7:0]  prev_a;
  always @(negedge clk) begin
    exp_t        e;
    logic [12:0] off13;
    if (mon_en) begin
      if (err) err_seen++;
      if (start) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("stall_valid", 64'(out_valid), 64'd1);
          check("stall_instr", 64'(instruction), 64'(prev_i));
          check("stall_addr", 64'(instr_addr), 64'(prev_a));
        end
        if (out_valid && out_ready) begin
          check("word_expected", 64'(sb.size() != 0), 64'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("instruction", 64'(instruction), 64'(e.w));
            check("instr_addr", 64'(instr_addr), 64'(e.a));
            if (e.is_b) begin
              off13 = {instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0};
              check("branch_roundtrip", 64'(off13[12:1]), 64'(e.imm12));
            end
          end
        end
        stall_prev = out_valid && !out_ready;
        prev_i = instruction;
        prev_a = instr_addr;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bnd_t b;
    int   b_cyc;
    int   r;
    logic [11:0] v;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_instruction", 64'(instruction), 64'd0);
    check("rst_addr", 64'(instr_addr), 64'(BASE));
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("idle_in_ready", 64'(in_ready), 64'd0);
    mon_en = 1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    man_rdy = 1;
    do_start();

    // Unsupported opcode: consumed, err pulse, no word.
    send(mk(7'h7F, 5'd1, 5'd2, 5'd3, 3'd0, 64'd0), 0, 0, '0);
    @(negedge clk);
    check("badop_err", 64'(err), 64'd1);
    check("badop_no_word", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("badop_err_pulse", 64'(err), 64'd0);
    @(posedge clk); #1;

    send(mk(7'h13, 5'd5, 5'd1, 5'd0, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF), 0, 1, 32'hFFF08293);
    send(mk(7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 64'd8), 0, 1, 32'h0021A423);
    send(mk(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 64'd4), 0, 1, 32'h00208463);
    // imm=2048: dropped with range checking, truncated without.
    send(mk(7'h13, 5'd6, 5'd7, 5'd0, 3'd0, 64'd2048), 0, 0, '0);
`ifdef IMM_RANGE_CHECK_EN
    @(negedge clk);
    check("range_err", 64'(err), 64'd1);
    check("range_no_word", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
`endif
    wait_drain("drain_directed");

    // Stall: out_ready low, a second bundle waits and nothing moves.
    man_rdy = 0;
    @(posedge clk); #1;
    send(mk(7'h33, 5'd10, 5'd11, 5'd12, 3'd0, 64'd0), 0, 0, '0);
    fork
      send(mk(7'h03, 5'd13, 5'd14, 5'd0, 3'd3, 64'hFFFF_FFFF_FFFF_FFF0), 1, 0, '0);
      begin
        repeat (5) begin
          @(negedge clk);
          check("stall_in_ready", 64'(in_ready), 64'd0);
        end
        man_rdy = 1;
      end
    join
    b_cyc = last_acc;
    send(mk(7'h23, 5'd0, 5'd15, 5'd16, 3'd3, 64'hFFFF_FFFF_FFFF_F800), 1, 0, '0);
    send(mk(7'h63, 5'd0, 5'd17, 5'd18, 3'd1, 64'd2047), 0, 0, '0);
    check("back_to_back", 64'(last_acc - b_cyc), 64'd2);
    while (words < DEPTH) send(mk(7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 64'd1), 0, 0, '0);
    wait_drain("drain_stall");
    wait_done("done_prog1");

    // start while a word is stalled: word discarded, address back to base.
    do_start();
    man_rdy = 0;
    @(posedge clk); #1;
    send(mk(7'h13, 5'd2, 5'd3, 5'd0, 3'd1, 64'd5), 0, 0, '0);
    @(negedge clk);
    check("midstall_pending", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    do_start();
    @(negedge clk);
    check("restart_out_valid", 64'(out_valid), 64'd0);
    check("restart_addr", 64'(instr_addr), 64'(BASE));
    check("restart_done", 64'(done), 64'd0);
    man_rdy = 1;
    @(posedge clk); #1;
    send(mk(7'h33, 5'd4, 5'd5, 5'd6, 3'd7, 64'd0), 0, 0, '0);
    wait_drain("drain_restart");

    // Randomized programs with random back-pressure.
    for (int p = 0; p < 6; p++) begin
      do_start();
      rand_rdy = 1;
      while (words < DEPTH) begin
        r = $urandom_range(0, 9);
        case (r)
          0, 1: b.op = 7'h33;
          2:    b.op = 7'h03;
          3, 4: b.op = 7'h13;
          5, 6: b.op = 7'h23;
          7, 8: b.op = 7'h63;
          default: b.op = 7'h7F;
        endcase
        b.rd = 5'($urandom); b.rs1 = 5'($urandom); b.rs2 = 5'($urandom);
        b.f3 = 3'($urandom); b.f7 = 7'($urandom);
        v = 12'($urandom);
        if ($urandom_range(0, 3) != 0) b.imm = {{52{v[11]}}, v};
        else                            b.imm = {$urandom, $urandom};
        send(b, ($urandom_range(0, 1) == 1) && (words < DEPTH - 1), 0, '0);
      end
      in_valid = 1'b0;
      wait_drain("drain_random");
      rand_rdy = 0;
      wait_done("done_random");
    end

    repeat (3) @(negedge clk);
    check("err_pulses", 64'(err_seen), 64'(errs_issued));
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
